// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter giving the fetch and data ports shared access to one word-wide memory.
// It places byte accesses on byte lanes, rejects odd-address word accesses and reports when it is idle.
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              quiesce,
    output logic              idle,
    input  logic              ifReq,
    input  logic [ADDR_W-1:0] ifAddr,
    output logic              ifGnt,
    output logic              ifValid,
    output logic              ifErr,
    output logic [15:0]       ifRdata,
    input  logic              dReq,
    input  logic              dWe,
    input  logic              dByte,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [15:0]       dWdata,
    output logic              dGnt,
    output logic              dValid,
    output logic              dErr,
    output logic [15:0]       dRdata,
    output logic              memEn,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [1:0]        memBe,
    output logic [15:0]       memWdata,
    input  logic [15:0]       memRdata
);
    typedef enum logic [2:0] {IDLE, ACCESS, WAIT, RESP, ERR} state_t;
    state_t      state_q;
    logic        d_first_q, win_q, we_q, byte_q, odd_q;
    logic [2:0]  cnt_q;
    logic        win_d, we_d, byte_d, mis_d;
    logic [ADDR_W-1:0] addr_d;
    logic [15:0] rd_d;
    // A lone requester wins; on a collision the pointer decides.
    assign win_d  = dReq & (~ifReq | d_first_q);
    assign we_d   = win_d & dWe;
    assign byte_d = win_d & dByte;
    assign addr_d = win_d ? dAddr : ifAddr;
    assign mis_d  = ~byte_d & addr_d[0];
    assign rd_d   = we_q ? 16'h0000 : !byte_q ? memRdata : {8'h00, odd_q ? memRdata[7:0] : memRdata[15:8]};
    assign idle   = state_q == IDLE;
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q   <= IDLE;
            d_first_q <= 1'b1;
            win_q     <= 1'b0;
            we_q      <= 1'b0;
            byte_q    <= 1'b0;
            odd_q     <= 1'b0;
            cnt_q     <= '0;
            ifGnt     <= 1'b0;
            ifValid   <= 1'b0;
            ifErr     <= 1'b0;
            ifRdata   <= '0;
            dGnt      <= 1'b0;
            dValid    <= 1'b0;
            dErr      <= 1'b0;
            dRdata    <= '0;
            memEn     <= 1'b0;
            memWe     <= 1'b0;
            memAddr   <= '0;
            memBe     <= '0;
            memWdata  <= '0;
        end else begin
            ifGnt    <= 1'b0;
            ifValid  <= 1'b0;
            ifErr    <= 1'b0;
            dGnt     <= 1'b0;
            dValid   <= 1'b0;
            dErr     <= 1'b0;
            memEn    <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memBe    <= '0;
            memWdata <= '0;
            case (state_q)
                IDLE: if (!quiesce && (ifReq || dReq)) begin
                    win_q     <= win_d;
                    we_q      <= we_d;
                    byte_q    <= byte_d;
                    odd_q     <= addr_d[0];
                    d_first_q <= ~win_d;
                    dGnt      <= win_d;
                    ifGnt     <= ~win_d;
                    if (mis_d) begin
                        state_q <= ERR;
                        dErr    <= win_d;
                        ifErr   <= ~win_d;
                    end else begin
                        state_q  <= ACCESS;
                        memEn    <= 1'b1;
                        memWe    <= we_d;
                        memAddr  <= {addr_d[ADDR_W-1:1], 1'b0};
                        memBe    <= byte_d ? (addr_d[0] ? 2'b01 : 2'b10) : 2'b11;
                        memWdata <= !we_d ? 16'h0000 : byte_d ? {2{dWdata[7:0]}} : dWdata;
                    end
                end
                ACCESS: begin
                    state_q <= WAIT;
                    cnt_q   <= 3'(MEM_LAT - 1);
                end
                // Leaving WAIT lands exactly on the edge where the read word is valid.
                WAIT: if (cnt_q == 3'd0) begin
                    state_q <= RESP;
                    dValid  <= win_q;
                    ifValid <= ~win_q;
                    if (win_q) dRdata <= rd_d;
                    else ifRdata <= rd_d;
                end else begin
                    cnt_q <= cnt_q - 3'd1;
                end
                RESP: state_q <= IDLE;
                ERR: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
